// File: rtl/tokenflow.sv
// tokenflow: token source emitting x*(x+1) mod 2^w on a 4-phase req/ack channel.
// Each product comes from a w-cycle shift-add multiplier. The acknowledge
// arrives asynchronously and is brought into the clock domain by two flops.
module tokenflow #(
  parameter int w = 16
) (
  input  logic         clk,
  input  logic         reset,
  output logic         ou_req,
  input  logic         ou_ack,
  output logic [w-1:0] ou_data
);

  localparam int CW = $clog2(w + 1);
  localparam logic [w-1:0]  ONE      = {{(w-1){1'b0}}, 1'b1};
  localparam logic [w-1:0]  ZERO     = {w{1'b0}};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = CW'(w - 1);

  typedef enum logic [2:0] {
    LOAD        = 3'd0,
    CALC        = 3'd1,
    SETUP       = 3'd2,
    WAIT_ACK_HI = 3'd3,
    WAIT_ACK_LO = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          ack_m;
  logic          ack_s;
  logic [w-1:0]  x;
  logic [w-1:0]  a;
  logic [w-1:0]  b;
  logic [w-1:0]  acc;
  logic [w-1:0]  acc_sum;
  logic [CW-1:0] cnt;
  logic          calc_last;

  // One shift-add step: add the multiplicand when the current multiplier bit is set.
  function automatic logic [w-1:0] mac_step(input logic [w-1:0] acc_in,
                                            input logic [w-1:0] a_in,
                                            input logic         b_bit);
    logic [w-1:0] res;
    if (b_bit) begin
      res = acc_in + a_in;
    end else begin
      res = acc_in;
    end
    return res;
  endfunction

  // Two-flop synchronizer for the asynchronous acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= ou_ack;
      ack_s <= ack_m;
    end
  end

  // Multiplier step result and detection of the final multiply cycle.
  always_comb begin
    acc_sum   = mac_step(acc, a, b[0]);
    calc_last = (cnt == CNT_LAST);
  end

  // Handshake/multiply state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; the channel only advances on the synchronized ack.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: begin
        state_nxt = CALC;
      end
      CALC: begin
        if (calc_last) begin
          state_nxt = SETUP;
        end else begin
          state_nxt = CALC;
        end
      end
      SETUP: begin
        state_nxt = WAIT_ACK_HI;
      end
      WAIT_ACK_HI: begin
        if (ack_s) begin
          state_nxt = WAIT_ACK_LO;
        end else begin
          state_nxt = WAIT_ACK_HI;
        end
      end
      WAIT_ACK_LO: begin
        if (!ack_s) begin
          state_nxt = LOAD;
        end else begin
          state_nxt = WAIT_ACK_LO;
        end
      end
      default: begin
        state_nxt = LOAD;
      end
    endcase
  end

  // Datapath: operand load, shift-add iterations, output capture and handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      x       <= ZERO;
      a       <= ZERO;
      b       <= ZERO;
      acc     <= ZERO;
      cnt     <= CNT_ZERO;
      ou_req  <= 1'b0;
      ou_data <= ZERO;
    end else begin
      case (state)
        LOAD: begin
          a   <= x;
          b   <= x + ONE;
          acc <= ZERO;
          cnt <= CNT_ZERO;
        end
        CALC: begin
          acc <= acc_sum;
          a   <= {a[w-2:0], 1'b0};
          b   <= {1'b0, b[w-1:1]};
          cnt <= cnt + CNT_ONE;
          // ou_data only moves here, while req and ack_s are both low.
          if (calc_last) begin
            ou_data <= acc_sum;
          end
        end
        SETUP: begin
          ou_req <= 1'b1;
        end
        WAIT_ACK_HI: begin
          if (ack_s) begin
            ou_req <= 1'b0;
            x      <= x + ONE;
          end
        end
        WAIT_ACK_LO: begin
          ou_req <= 1'b0;
        end
        default: begin
          ou_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tokenflow.sv
// tb_tokenflow: scenario tasks for tokenflow at w=16 and w=4, checked against
// an arithmetic model of the token sequence and the handshake timing.
module tb_tokenflow;

  logic        clk = 1'b0;
  logic        reset16 = 1'b1;
  logic        reset4 = 1'b1;
  logic        req16;
  logic        req4;
  logic        ack16;
  logic        ack4;
  logic        ack_drv16 = 1'b0;
  logic        loop16 = 1'b0;
  logic [15:0] data16;
  logic [3:0]  data4;
  int          checks = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  assign ack16 = loop16 ? req16 : ack_drv16;
  assign ack4  = req4;

  tokenflow #(.w(16)) dut (
    .clk(clk), .reset(reset16), .ou_req(req16), .ou_ack(ack16), .ou_data(data16)
  );

  tokenflow #(.w(4)) dut4 (
    .clk(clk), .reset(reset4), .ou_req(req4), .ou_ack(ack4), .ou_data(data4)
  );

  function automatic logic [15:0] prod16(input int x);
    longint p;
    p = longint'(x % 65536) * longint'((x % 65536) + 1);
    return 16'(p % 65536);
  endfunction

  function automatic logic [3:0] prod4(input int x);
    int xm;
    xm = x % 16;
    return 4'((xm * (xm + 1)) % 16);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset16();
    reset16 = 1'b1;
    tick();
    tick();
    reset16 = 1'b0;
  endtask

  task automatic wait_req16(input logic level, input int bound, output int n);
    n = 0;
    while (req16 !== level && n < bound) begin
      tick();
      n++;
    end
    if (req16 !== level) begin
      checks++;
      fails++;
      $display("FAIL wait_req16: req=%b after %0d cycles, required %b", req16, n, level);
    end
  endtask

  task automatic test_reset();
    reset16 = 1'b1;
    reset4 = 1'b1;
    tick();
    tick();
    checks += 4;
    if (req16 !== 1'b0) begin fails++; $display("FAIL reset_req16: got %b want 0", req16); end
    if (data16 !== 16'd0) begin fails++; $display("FAIL reset_data16: got %0d want 0", data16); end
    if (req4 !== 1'b0) begin fails++; $display("FAIL reset_req4: got %b want 0", req4); end
    if (data4 !== 4'd0) begin fails++; $display("FAIL reset_data4: got %0d want 0", data4); end
  endtask

  task automatic test_loopback();
    int n;
    loop16 = 1'b1;
    apply_reset16();
    wait_req16(1'b1, 100, n);
    checks++;
    if (n != 18) begin fails++; $display("FAIL first_latency: got %0d edges want 18", n); end
    for (int k = 0; k < 10; k++) begin
      if (k > 0) wait_req16(1'b1, 100, n);
      checks++;
      if (data16 !== prod16(k)) begin
        fails++; $display("FAIL loop_token[%0d]: got %0d want %0d", k, data16, prod16(k));
      end
      wait_req16(1'b0, 20, n);
      checks += 2;
      if (n != 3) begin fails++; $display("FAIL loop_req_width[%0d]: got %0d want 3", k, n); end
      if (data16 !== prod16(k)) begin
        fails++; $display("FAIL loop_hold[%0d]: got %0d want %0d", k, data16, prod16(k));
      end
    end
  endtask

  task automatic test_stall();
    int n;
    loop16 = 1'b0;
    ack_drv16 = 1'b0;
    apply_reset16();
    wait_req16(1'b1, 100, n);
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if (req16 !== 1'b1 || data16 !== 16'd0) begin
        fails++; $display("FAIL stall_low[%0d]: req=%b data=%0d want req=1 data=0", i, req16, data16);
      end
    end
    ack_drv16 = 1'b1;
    wait_req16(1'b0, 20, n);
    checks++;
    if (n != 3) begin fails++; $display("FAIL stall_release: req fell after %0d edges want 3", n); end
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (req16 !== 1'b0) begin fails++; $display("FAIL stall_high[%0d]: req=%b want 0", i, req16); end
    end
    ack_drv16 = 1'b0;
    wait_req16(1'b1, 100, n);
    checks++;
    if (data16 !== 16'd2) begin fails++; $display("FAIL stall_next: got %0d want 2", data16); end
    ack_drv16 = 1'b1;
    wait_req16(1'b0, 20, n);
    ack_drv16 = 1'b0;
  endtask

  task automatic test_handshake();
    int          tokens;
    int          x;
    int          dly;
    int          hi_ticks;
    int          lo_ticks;
    int          cyc;
    logic        prev_req;
    logic [15:0] prev_data;
    loop16 = 1'b0;
    ack_drv16 = 1'b0;
    apply_reset16();
    tokens = 0;
    x = 0;
    dly = 0;
    hi_ticks = 0;
    lo_ticks = 100;
    cyc = 0;
    prev_req = req16;
    prev_data = data16;
    while (tokens < 30 && cyc < 4000) begin
      tick();
      cyc++;
      if (ack_drv16) hi_ticks++; else lo_ticks++;
      if (prev_req === 1'b1 || req16 === 1'b1) begin
        checks++;
        if (data16 !== prev_data) begin
          fails++; $display("FAIL hs_data_stable: got %0d want %0d (req %b->%b)", data16, prev_data, prev_req, req16);
        end
      end
      if (req16 === 1'b1 && prev_req === 1'b0) begin
        checks += 2;
        if (data16 !== prod16(x)) begin
          fails++; $display("FAIL hs_token[%0d]: got %0d want %0d", x, data16, prod16(x));
        end
        if (lo_ticks < 2) begin
          fails++; $display("FAIL hs_rerise: ack low for %0d edges want >=2", lo_ticks);
        end
        x++;
        dly = $urandom_range(0, 5);
      end
      if (req16 === 1'b0 && prev_req === 1'b1) begin
        checks++;
        if (hi_ticks != 3) begin
          fails++; $display("FAIL hs_fall_delay: got %0d edges want 3", hi_ticks);
        end
        dly = $urandom_range(0, 5);
        tokens++;
      end
      if (req16 === 1'b1 && !ack_drv16) begin
        if (dly == 0) begin ack_drv16 = 1'b1; hi_ticks = 0; end
        else dly--;
      end else if (req16 === 1'b0 && ack_drv16) begin
        if (dly == 0) begin ack_drv16 = 1'b0; lo_ticks = 0; end
        else dly--;
      end
      prev_req = req16;
      prev_data = data16;
    end
    checks++;
    if (tokens != 30) begin fails++; $display("FAIL hs_progress: got %0d tokens want 30", tokens); end
    ack_drv16 = 1'b0;
  endtask

  task automatic test_wrap();
    int n;
    reset4 = 1'b1;
    tick();
    tick();
    reset4 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      n = 0;
      while (req4 !== 1'b1 && n < 100) begin tick(); n++; end
      checks++;
      if (req4 !== 1'b1 || data4 !== prod4(k)) begin
        fails++; $display("FAIL wrap_token[%0d]: req=%b data=%0d want req=1 data=%0d", k, req4, data4, prod4(k));
      end
      n = 0;
      while (req4 !== 1'b0 && n < 20) begin tick(); n++; end
    end
    reset4 = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n;
    loop16 = 1'b0;
    ack_drv16 = 1'b0;
    apply_reset16();
    wait_req16(1'b1, 100, n);
    ack_drv16 = 1'b1;
    wait_req16(1'b0, 20, n);
    ack_drv16 = 1'b0;
    wait_req16(1'b1, 100, n);
    n = $urandom_range(0, 10);
    for (int i = 0; i < n; i++) tick();
    reset16 = 1'b1;
    tick();
    checks += 2;
    if (req16 !== 1'b0) begin fails++; $display("FAIL midreset_req: got %b want 0", req16); end
    if (data16 !== 16'd0) begin fails++; $display("FAIL midreset_data: got %0d want 0", data16); end
    reset16 = 1'b0;
    wait_req16(1'b1, 100, n);
    checks += 2;
    if (n != 18) begin fails++; $display("FAIL midreset_latency: got %0d want 18", n); end
    if (data16 !== 16'd0) begin fails++; $display("FAIL midreset_first: got %0d want 0", data16); end
    ack_drv16 = 1'b1;
    wait_req16(1'b0, 20, n);
    ack_drv16 = 1'b0;
  endtask

  task automatic test_product();
    int n;
    loop16 = 1'b1;
    apply_reset16();
    for (int k = 0; k <= 300; k++) begin
      wait_req16(1'b1, 100, n);
      checks++;
      if (data16 !== prod16(k)) begin
        fails++; $display("FAIL prod_token[%0d]: got %0d want %0d", k, data16, prod16(k));
      end
      if (k == 255) begin
        checks++;
        if (data16 !== 16'hFF00) begin fails++; $display("FAIL prod_255: got %0h want ff00", data16); end
      end
      if (k == 300) begin
        checks++;
        if (data16 !== 16'd24764) begin fails++; $display("FAIL prod_300: got %0d want 24764", data16); end
      end
      wait_req16(1'b0, 20, n);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_stall();
    test_handshake();
    test_wrap();
    test_reset_mid();
    test_product();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/tokenflow.md
Name: tokenflow

Overview:
Self-timed-style token source that emits the sequence x*(x+1) mod 2^w for x = 0, 1, 2, … (0, 2, 6, 12, 20, 30, …). Each value is delivered on an output channel that uses a 4-phase return-to-zero bundled-data handshake (req/ack). Each product is computed by an internal multi-cycle shift-add multiplier. The block sits behind the chip top level: data and req drive the output pins, and ack comes from an input pin (ack may be externally tied to req to get a free-running stream).

Parameters:
w, 16, width of the sequence counter, the multiplier and ou_data (results are modulo 2^w)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
ou_req  output  1  channel request; high = ou_data valid
ou_ack  input  1  channel acknowledge from consumer; asynchronous to clk
ou_data  output  w  channel data, bundled with ou_req

Behaviour:
Interface rule: one clock (clk); reset is synchronous and active-high (reset).

Reset, sampled on a rising clk edge:
- ou_req=0, ou_data=0, x=0, ack synchronizer flops=0, state=LOAD.
- Reset asserted mid-operation aborts everything: ou_req drops at that edge regardless of ou_ack, and the sequence restarts at x=0.

Ack synchronization:
- ou_ack passes through 2 flops to give ack_s.
- All decisions use ack_s only.

State machine (one transition per rising edge):
- LOAD: a<=x; b<=x+1 (mod 2^w); acc<=0; cnt<=0; go to CALC.
- CALC: exactly w cycles. Each cycle:
  - if b[0], acc<=acc+a (mod 2^w);
  - a<=a<<1; b<=b>>1; cnt<=cnt+1.
  - On the w-th cycle, ou_data<=final acc; go to SETUP.
- SETUP: 1 cycle with data stable; ou_req<=1; go to WAIT_ACK_HI.
- WAIT_ACK_HI: hold until ack_s=1; then ou_req<=0, x<=x+1 (mod 2^w); go to WAIT_ACK_LO.
- WAIT_ACK_LO: hold until ack_s=0; then go to LOAD.

Output and timing rules:
- ou_data changes only at the end of CALC, i.e. only while ou_req=0 and ack_s=0. It is held stable from at least 1 cycle before ou_req rises until after ou_req falls, and also through the following LOAD/CALC.
- Latency: ou_req is high after the (w+2)-th rising edge following the first edge with reset=0.
- Per token, with ack tied to req: ack_s rises 2 edges after req rises; ou_req falls at the next edge; then ack_s falls 2 edges later, followed by LOAD, w CALC cycles and SETUP.
- ou_ack must not be asserted before ou_req. An early ou_ack high seen in WAIT_ACK_LO or LOAD/CALC/SETUP is ignored until WAIT_ACK_HI.

Wrap-around:
- x = 2^w−1 makes x+1 = 0, so the product is 0; the next x is 0, restarting the sequence (0, 2, …).
- All products are truncated to w bits.

Stall:
- ou_ack held low keeps ou_req high and ou_data constant indefinitely.
- ou_ack held high after the req fall keeps ou_req low; no new token is issued.

Test Plan:
1. Reset 2 cycles, then ack tied to req, w=16 → req pulses carry 0, 2, 6, 12, 20, 30, 42, 56, 72, 90 in order; first req high w+2=18 edges after reset release.
2. Ack held 0 after the first req → req stays 1 and data stays 0 for 100 cycles; raising ack → req falls 3 edges later; next token is 2.
3. Handshake check → data never changes while req=1 or within 1 cycle before req rises; req never re-rises until ack has been low (sync'd).
4. Wrap, w=4, loopback → data sequence 0, 2, 6, 12, 4 (20 mod 16), 14 (30 mod 16), 10, 8, 8, 10, 14, 4, 12, 6, 2, 0 (x=15), then 0 (x=0), 2, … repeating.
5. Reset asserted while req=1 and ack=0 → req=0 and data=0 at that edge; after release the first token is 0.
6. Product check for x=255, w=16 → data = 255*256 mod 65536 = 65280 (0xFF00); x=300 → 90300 mod 65536 = 24764.
